sync_fifo_flags: RTL

Parametrised single-clock FIFO with occupancy counter. It is the successor to the basic counter-based sync FIFO.
- Adds programmable almost-full and almost-empty thresholds.
- Adds overflow and underflow error pulses.
- Adds a selectable first-word-fall-through (FWFT) read mode.
- Used as the generic buffering primitive between datapath stages sharing one clock.

---
 rtl/sync_fifo_flags_if.sv | 41 ++++
 rtl/sync_fifo_flags.sv | 131 +++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_flags_if
// Description : Bus bundle between a producer/consumer and sync_fifo_flags.
//               The master side pushes/pops and observes status; the slave
//               side is the FIFO itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_flags_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 8
);
    localparam int c_CNT_W = $clog2(DATA_DEPTH) + 1;

    logic [DATA_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [c_CNT_W-1:0]    fifo_cnt;
    logic                  overflow;
    logic                  underflow;

    // Producer/consumer view: drives requests, observes data and status.
    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, empty, full, almost_empty, almost_full,
               fifo_cnt, overflow, underflow
    );

    // FIFO view: receives requests, drives data and status.
    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, empty, full, almost_empty, almost_full,
               fifo_cnt, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_flags.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_flags
// Description : Single-clock FIFO with occupancy counter, programmable
//               almost-full/almost-empty thresholds, registered overflow /
//               underflow pulses and selectable standard or FWFT read mode.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DATA_DEPTH = 8,
    parameter int AF_LEVEL   = DATA_DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int FWFT       = 0
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    sync_fifo_flags_if.slave  bus
);

    localparam int c_PTR_W = $clog2(DATA_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DATA_DEPTH);
    localparam logic [c_CNT_W-1:0] c_AF_CNT    = c_CNT_W'(AF_LEVEL);
    localparam logic [c_CNT_W-1:0] c_AE_CNT    = c_CNT_W'(AE_LEVEL);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

    // Storage, pointers and occupancy
    logic [DATA_WIDTH-1:0] r_mem [DATA_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_overflow;
    logic                  r_underflow;

    // Decoded status and acceptance
    logic w_empty;
    logic w_full;
    logic w_rd_acc;
    logic w_wr_acc;

    // All flags come straight from the count register, so they track the
    // post-edge occupancy with no additional latency.
    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == c_DEPTH_CNT);

    // A write into a full FIFO is still accepted when a read frees a slot in
    // the same edge; a read from an empty FIFO is never accepted, even if a
    // write lands simultaneously.
    assign w_rd_acc = bus.rd_en & ~w_empty;
    assign w_wr_acc = bus.wr_en & (~w_full | w_rd_acc);

    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.almost_empty = (r_cnt <= c_AE_CNT);
    assign bus.almost_full  = (r_cnt >= c_AF_CNT);
    assign bus.fifo_cnt     = r_cnt;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

    // Memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    // Pointers advance on acceptance and wrap naturally at DATA_DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Occupancy: net change of accepted writes minus accepted reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_cnt <= r_cnt + c_CNT_ONE;
                2'b01:   r_cnt <= r_cnt - c_CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Error pulses: a single cycle per rejected request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= bus.wr_en & ~w_wr_acc;
            r_underflow <= bus.rd_en & ~w_rd_acc;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally; zero while empty so a
            // stale entry never leaks out after a drain or a reset.
            assign bus.data_out = w_empty ? '0 : r_mem[r_rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data_out;

            // Registered read: load the head on an accepted pop, else hold.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data_out <= '0;
                end else if (w_rd_acc) begin
                    r_data_out <= r_mem[r_rd_ptr];
                end
            end

            assign bus.data_out = r_data_out;
        end
    endgenerate

endmodule
`default_nettype wire
